i2c_eeprom_slave: RTL and testbench



---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 39 +++
 rtl/i2c_eeprom_slave.sv | 185 ++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM target.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_ADDR      = 4'd3,
        ST_ADDR_ACK  = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } i2c_slv_st_t;

    localparam logic [6:0] I2C_DEV_ADDR = 7'h50;
    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;
    localparam int         I2C_RW_BIT   = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
// All outputs are registered, so events appear 3 clk after the pin edge.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [0] first flop, [1] synchronized, [2] previous synchronized value
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl     <= 3'b111;
            r_sda     <= 3'b111;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            r_scl     <= {r_scl[1:0], scl};
            r_sda     <= {r_sda[1:0], sda};
            scl_rise  <= r_scl[1] & ~r_scl[2];
            scl_fall  <= ~r_scl[1] & r_scl[2];
            start_det <= r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
            stop_det  <= r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];
            sda_s     <= r_sda[1];
        end
    end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target modelling a small serial EEPROM: word-address writes,
// sequential data writes and current-address sequential reads.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR,
    parameter int         SIZE     = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scl,
    inout  wire                     sda,
    output logic                    busy,
    output logic                    wr_pulse,
    output logic [$clog2(SIZE)-1:0] wr_addr,
    output logic [7:0]              wr_data
);

    localparam int AW = $clog2(SIZE);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    i2c_slv_st_t   r_state;
    logic [3:0]    r_bitcnt;
    logic [6:0]    r_shift;
    logic [7:0]    r_rd_byte;
    logic [AW-1:0] r_ptr;
    logic          r_sda_oe;
    logic          r_ack_drv;
    logic          r_rw;
    logic [7:0]    r_mem [SIZE];

    logic [7:0]    w_byte;
    logic [AW-1:0] w_ptr_inc;
    logic          w_last_bit;

    assign w_byte     = {r_shift, w_sda_s};
    assign w_ptr_inc  = r_ptr + AW'(1);
    assign w_last_bit = (r_bitcnt == 4'd7);

    // Open-drain: only ever pull low or let go.
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (wr_pulse) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= 4'd0;
            r_shift   <= 7'd0;
            r_rd_byte <= 8'd0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_ack_drv <= 1'b0;
            r_rw      <= 1'b0;
            busy      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
        end else begin
            wr_pulse <= 1'b0;
            if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_ack_drv <= 1'b0;
                busy      <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_DEV;
                r_bitcnt  <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_ack_drv <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    busy      <= 1'b1;
                                    r_rw      <= w_byte[I2C_RW_BIT];
                                    r_rd_byte <= r_mem[r_ptr];
                                    r_state   <= ST_DEV_ACK;
                                end else begin
                                    busy    <= 1'b0;
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_ptr   <= w_byte[AW-1:0];
                                r_state <= ST_ADDR_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                wr_pulse <= 1'b1;
                                wr_addr  <= r_ptr;
                                wr_data  <= w_byte;
                                r_ptr    <= w_ptr_inc;
                                r_state  <= ST_WDATA_ACK;
                            end
                        end
                    end
                    // First fall after the byte starts the ACK, the second one ends it.
                    ST_DEV_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sda_oe  <= (I2C_ACK == 1'b0);
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_ack_drv <= 1'b0;
                                r_bitcnt  <= 4'd0;
                                if (r_state == ST_DEV_ACK && r_rw) begin
                                    r_sda_oe <= ~r_rd_byte[7];
                                    r_state  <= ST_RDATA;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == ST_DEV_ACK) ? ST_ADDR : ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= ~r_rd_byte[3'd7 - r_bitcnt[2:0]];
                        end else if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_state <= ST_RDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                        end else if (w_scl_rise) begin
                            r_ptr <= w_ptr_inc;
                            if (w_sda_s == I2C_ACK) begin
                                r_rd_byte <= r_mem[w_ptr_inc];
                                r_bitcnt  <= 4'd0;
                                r_state   <= ST_RDATA;
                            end else begin
                                busy    <= 1'b0;
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master driving the EEPROM target, with write/read scoreboards.
module tb_i2c_eeprom_slave;

    localparam time Q = 60ns;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic       scl_m;
    logic       sda_drv;
    wire        sda;
    logic       busy;
    logic       wr_pulse;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int   total = 0;
    int   bad   = 0;
    int   n_wr  = 0;
    wr_t  exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_t  mon_e;

    assign sda = sda_drv ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_eeprom_slave #(.DEV_ADDR(7'h50), .SIZE(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl_m),
        .sda      (sda),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5ns clk = ~clk;

    // Write scoreboard: every stored byte must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && wr_pulse) begin
            n_wr++;
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== {mon_e.a, mon_e.d}) begin
                    bad++;
                    $display("FAIL wr_pulse: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic bus_start();
        sda_drv = 1'b0; #Q;
        scl_m   = 1'b1; #Q;
        sda_drv = 1'b1; #Q;
        scl_m   = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_drv = 1'b1; #Q;
        scl_m   = 1'b1; #Q;
        sda_drv = 1'b0; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_drv = ~b; #Q;
        scl_m   = 1'b1; #(2*Q);
        scl_m   = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b0; #Q;
        scl_m   = 1'b1; #Q;
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        #Q;
        scl_m   = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(ack);
    endtask

    task automatic set_ptr(input logic [7:0] a);
        logic ack;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(a, ack);
        bus_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl_m = 1'b1; sda_drv = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL rst_wr_pulse: got %b want 0", wr_pulse); end
        total++; if (wr_addr !== 6'h00) begin bad++; $display("FAIL rst_wr_addr: got %h want 00", wr_addr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
        total++; if (sda === 1'b0) begin bad++; $display("FAIL rst_sda: got %b want released", sda); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write3();
        logic ack;
        bus_start();
        send_byte(8'hA0, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL w3_dev_ack: got %b want 0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL w3_busy: got %b want 1", busy); end
        send_byte(8'h10, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL w3_addr_ack: got %b want 0", ack); end
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back('{a: 6'(8'h10 + i), d: 8'(8'h01 + i)});
            send_byte(8'(8'h01 + i), ack);
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL w3_data_ack%0d: got %b want 0", i, ack); end
        end
        bus_stop();
        repeat (6) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL w3_busy_stop: got %b want 0", busy); end
        total++; if (exp_wr.size() != 0) begin bad++; $display("FAIL w3_pending: got %0d left want 0", exp_wr.size()); end
    endtask

    task automatic test_readback();
        logic ack;
        logic [7:0] v;
        logic [7:0] e;
        set_ptr(8'h10);
        bus_start();
        send_byte(8'hA1, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rb_dev_ack: got %b want 0", ack); end
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(8'(8'h01 + i));
            recv_byte(v, (i == 2));
            e = exp_rd.pop_front();
            total++; if (v !== e) begin bad++; $display("FAIL rb_byte%0d: got %h want %h", i, v, e); end
        end
        total++; if (sda === 1'b0) begin bad++; $display("FAIL rb_sda_after_nack: got %b want released", sda); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rb_busy_after_nack: got %b want 0", busy); end
        bus_stop();
    endtask

    task automatic test_wrap();
        logic ack;
        logic [7:0] v;
        logic [7:0] e;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h3F, ack);
        exp_wr.push_back('{a: 6'h3F, d: 8'hAA});
        send_byte(8'hAA, ack);
        exp_wr.push_back('{a: 6'h00, d: 8'hBB});
        send_byte(8'hBB, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wrap_ack: got %b want 0", ack); end
        bus_stop();
        repeat (4) @(negedge clk);
        total++; if (exp_wr.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d left want 0", exp_wr.size()); end
        set_ptr(8'h3F);
        bus_start();
        send_byte(8'hA1, ack);
        exp_rd.push_back(8'hAA);
        recv_byte(v, 1'b0);
        e = exp_rd.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL wrap_rd0: got %h want %h", v, e); end
        exp_rd.push_back(8'hBB);
        recv_byte(v, 1'b1);
        e = exp_rd.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL wrap_rd1: got %h want %h", v, e); end
        bus_stop();
    endtask

    task automatic test_mismatch();
        logic ack;
        int   wr0;
        wr0 = n_wr;
        bus_start();
        send_byte(8'hA2, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL mm_dev_ack: got %b want 1", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mm_busy: got %b want 0", busy); end
        send_byte(8'h10, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL mm_byte_ack: got %b want 1", ack); end
        bus_stop();
        repeat (4) @(negedge clk);
        total++; if (n_wr != wr0) begin bad++; $display("FAIL mm_wr_pulse: got %0d pulses want 0", n_wr - wr0); end
    endtask

    task automatic test_rep_start();
        logic ack;
        logic [7:0] v;
        logic [7:0] e;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        exp_wr.push_back('{a: 6'h05, d: 8'h5A});
        send_byte(8'h5A, ack);
        bus_stop();
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        bus_start();
        send_byte(8'hA1, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_dev_ack: got %b want 0", ack); end
        exp_rd.push_back(8'h5A);
        recv_byte(v, 1'b1);
        e = exp_rd.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL rs_byte: got %h want %h", v, e); end
        bus_stop();
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h20, ack);
        exp_wr.push_back('{a: 6'h20, d: 8'h00});
        send_byte(8'h00, ack);
        bus_stop();
        set_ptr(8'h20);
        bus_start();
        send_byte(8'hA1, ack);
        sda_drv = 1'b0; #Q;
        scl_m   = 1'b1; #Q;
        total++; if (sda !== 1'b0) begin bad++; $display("FAIL rmr_bit7: got %b want 0", sda); end
        @(posedge clk); #1ns;
        rst_n = 1'b0;
        #2ns;
        total++; if (sda === 1'b0) begin bad++; $display("FAIL rmr_sda_release: got %b want released", sda); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_busy: got %b want 0", busy); end
        #Q;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_start();
        send_byte(8'hA0, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rmr_ack_after: got %b want 0", ack); end
        bus_stop();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write3();
        test_readback();
        test_wrap();
        test_mismatch();
        test_rep_start();
        test_reset_mid_read();
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL final_pending: got %0d writes left want 0", exp_wr.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
